nios_practica_led_sequencer: RTL and testbench



---
 rtl/nios_practica_led_sequencer_pkg.sv | 21 ++
 rtl/nios_practica_led_sequencer_if.sv | 14 +
 rtl/nios_practica_led_prescaler.sv | 36 +++
 rtl/nios_practica_led_sequencer.sv | 176 +++++++++++++++++
 tb/tb_nios_practica_led_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_practica_led_sequencer_pkg.sv
// Shared encodings for the LED PIO sequencer.
//   led_mode_e  : pattern generator modes selected by cfg_mode
//   seq_fsm_e   : bus-write FSM states
//   PIO_LED_ADDR: register offset of the LED PIO data register
package nios_practica_led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_BLINK    = 2'd1,
        MODE_ROTATE_L = 2'd2,
        MODE_BOUNCE   = 2'd3
    } led_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WR   = 1'b1
    } seq_fsm_e;

    localparam logic [1:0] PIO_LED_ADDR = 2'd0;

endpackage

// File: rtl/nios_practica_led_sequencer_if.sv
// Avalon-MM write-only link to the LED PIO s1 port.
//   address    : register offset (LED data register only)
//   chipselect : write strobe, one cycle per write
//   write_n    : active-low write qualifier
//   writedata  : 32-bit data word, pattern in the low byte
interface nios_practica_led_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    modport master (output address, output chipselect, output write_n, output writedata);
    modport slave  (input address, input chipselect, input write_n, input writedata);
endinterface

// File: rtl/nios_practica_led_prescaler.sv
// Step prescaler for the LED sequencer.
//   clk, reset_n : clock, async active-low reset
//   enable       : count while high; low clears the count and suppresses ticks
//   cfg_period   : clocks per step, 0 behaves as 1
//   tick         : one-cycle step pulse (combinational from the count)
module nios_practica_led_prescaler #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] last;

    // Greater-or-equal compare so a period shrunk below the running count
    // ticks on the next cycle instead of wrapping the counter.
    always_comb begin
        last = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
        tick = enable && (cnt >= last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/nios_practica_led_sequencer.sv
// LED PIO sequencer: Avalon-MM master generating timed LED patterns and
// arbitrating them against one-shot software writes (software has priority).
//   clk, reset_n  : clock, async active-low reset
//   enable        : run the prescaler / sequencer
//   cfg_mode      : STATIC, BLINK, ROTATE_L, BOUNCE
//   cfg_pattern   : base pattern
//   cfg_period    : clocks per step (0 behaves as 1)
//   sw_req/sw_data: software write request (level) and data
//   sw_ack        : pulse in the cycle the software write is on the bus
//   pio           : master side of the LED PIO link
//   cur_pattern   : last value written to the PIO
//   busy          : a write is on the bus
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | no bus activity, arbitrating sw_req vs tick_pend
// ST_WR   | single-cycle write strobe on the PIO
module nios_practica_led_sequencer
    import nios_practica_led_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          cfg_mode,
    input  logic [DATA_W-1:0]   cfg_pattern,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                sw_req,
    input  logic [DATA_W-1:0]   sw_data,
    output logic                sw_ack,
    nios_practica_led_sequencer_if.master pio,
    output logic [DATA_W-1:0]   cur_pattern,
    output logic                busy
);

    localparam logic [DATA_W-1:0] LED_LSB = DATA_W'(1);
    localparam logic [DATA_W-1:0] LED_MSB = LED_LSB << (DATA_W - 1);

    seq_fsm_e          state_q, state_d;
    logic              tick;
    logic              tick_pend_q, tick_pend_d;
    logic              enable_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seq_state_q, seq_state_d;
    logic              bounce_left_q, bounce_left_d;
    logic              blink_phase_q, blink_phase_d;
    logic              seq_fresh_q, seq_fresh_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              sw_ack_q, sw_ack_d;
    logic [DATA_W-1:0] seq_data;
    logic              seq_next_left;
    logic              load;

    nios_practica_led_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg_period (cfg_period),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            tick_pend_q   <= 1'b0;
            enable_q      <= 1'b0;
            mode_q        <= 2'd0;
            seq_state_q   <= '0;
            bounce_left_q <= 1'b1;
            blink_phase_q <= 1'b0;
            seq_fresh_q   <= 1'b1;
            wr_data_q     <= '0;
            sw_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_pend_q   <= tick_pend_d;
            enable_q      <= enable;
            mode_q        <= cfg_mode;
            seq_state_q   <= seq_state_d;
            bounce_left_q <= bounce_left_d;
            blink_phase_q <= blink_phase_d;
            seq_fresh_q   <= seq_fresh_d;
            wr_data_q     <= wr_data_d;
            sw_ack_q      <= sw_ack_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_pend_d   = tick_pend_q;
        seq_state_d   = seq_state_q;
        bounce_left_d = bounce_left_q;
        blink_phase_d = blink_phase_q;
        seq_fresh_d   = seq_fresh_q;
        wr_data_d     = wr_data_q;
        sw_ack_d      = 1'b0;
        seq_data      = cfg_pattern;
        seq_next_left = bounce_left_q;
        load          = (enable && !enable_q) || (cfg_mode != mode_q);

        // Value the next sequencer write would carry; the first write after
        // a load sends the loaded state untouched.
        case (led_mode_e'(cfg_mode))
            MODE_STATIC:   seq_data = cfg_pattern;
            MODE_BLINK:    seq_data = blink_phase_q ? '0 : cfg_pattern;
            MODE_ROTATE_L: seq_data = seq_fresh_q ? seq_state_q
                                    : {seq_state_q[DATA_W-2:0], seq_state_q[DATA_W-1]};
            MODE_BOUNCE: begin
                if (seq_fresh_q) begin
                    seq_data = seq_state_q;
                end else if (bounce_left_q) begin
                    if (seq_state_q == LED_MSB) begin
                        seq_data      = seq_state_q >> 1;
                        seq_next_left = 1'b0;
                    end else begin
                        seq_data = seq_state_q << 1;
                    end
                end else begin
                    if (seq_state_q == LED_LSB) begin
                        seq_data      = seq_state_q << 1;
                        seq_next_left = 1'b1;
                    end else begin
                        seq_data = seq_state_q >> 1;
                    end
                end
            end
            default: seq_data = cfg_pattern;
        endcase

        // One-deep tick capture; a clear by the FSM below overrides a tick
        // arriving while already pending, so that tick is dropped.
        if (!enable) begin
            tick_pend_d = 1'b0;
        end else if (tick) begin
            tick_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sw_req) begin
                    state_d   = ST_WR;
                    sw_ack_d  = 1'b1;
                    wr_data_d = sw_data;
                end else if (tick_pend_q && enable) begin
                    state_d       = ST_WR;
                    tick_pend_d   = 1'b0;
                    wr_data_d     = seq_data;
                    seq_state_d   = seq_data;
                    bounce_left_d = seq_next_left;
                    blink_phase_d = ~blink_phase_q;
                    seq_fresh_d   = 1'b0;
                end
            end
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            seq_state_d   = (led_mode_e'(cfg_mode) == MODE_BOUNCE) ? LED_LSB : cfg_pattern;
            bounce_left_d = 1'b1;
            blink_phase_d = 1'b0;
            seq_fresh_d   = 1'b1;
        end
    end

    assign pio.address    = PIO_LED_ADDR;
    assign pio.chipselect = (state_q == ST_WR);
    assign pio.write_n    = (state_q != ST_WR);
    assign pio.writedata  = {{(32 - DATA_W){1'b0}}, wr_data_q};
    assign busy           = (state_q == ST_WR);
    assign sw_ack         = sw_ack_q;
    assign cur_pattern    = wr_data_q;

endmodule

// File: tb/tb_nios_practica_led_sequencer.sv
module tb_nios_practica_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_pattern;
    logic [23:0] cfg_period;
    logic        sw_req;
    logic [7:0]  sw_data;
    logic        sw_ack;
    logic [7:0]  cur_pattern;
    logic        busy;

    nios_practica_led_sequencer_if pio();

    nios_practica_led_sequencer #(.PERIOD_W(24), .DATA_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg_mode    (cfg_mode),
        .cfg_pattern (cfg_pattern),
        .cfg_period  (cfg_period),
        .sw_req      (sw_req),
        .sw_data     (sw_data),
        .sw_ack      (sw_ack),
        .pio         (pio),
        .cur_pattern (cur_pattern),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] data;
        bit         sw;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: k-th sequencer write after a load, from the mode rules.
    function automatic logic [7:0] model_seq(input logic [1:0] m, input logic [7:0] p, input int k);
        logic [15:0] w;
        int          pos;
        int          idx;
        case (m)
            2'd0: return p;
            2'd1: return (k % 2 == 0) ? p : 8'h00;
            2'd2: begin
                w = {p, p} << (k % 8);
                return w[15:8];
            end
            default: begin
                pos = k % 14;
                idx = (pos <= 7) ? pos : 14 - pos;
                return 8'(1 << idx);
            end
        endcase
    endfunction

    function automatic int step_of(input logic [23:0] per);
        int eff;
        eff = (per == 0) ? 1 : int'(per);
        return (eff < 2) ? 2 : eff;
    endfunction

    task automatic push(input logic [7:0] d, input bit sw, input int c);
        exp_t e;
        e.data = d;
        e.sw   = sw;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic wait_cycle(input int c);
        int g = 0;
        while (cyc < c && g < 20000) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("pio_address", 32'(pio.address), 32'h0);
            if (pio.chipselect === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got data %h, none expected (cycle %0d)",
                             pio.writedata, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("writedata",   pio.writedata, {24'h0, e.data});
                    chk("write_cycle", 32'(cyc), 32'(e.cyc));
                    chk("sw_ack_wr",   32'(sw_ack), 32'(e.sw));
                    chk("write_n_wr",  32'(pio.write_n), 32'h0);
                    chk("busy_wr",     32'(busy), 32'h1);
                    chk("cur_pattern", 32'(cur_pattern), 32'(e.data));
                end
            end else begin
                chk("write_n_idle", 32'(pio.write_n), 32'h1);
                chk("busy_idle",    32'(busy), 32'h0);
                chk("sw_ack_idle",  32'(sw_ack), 32'h0);
            end
        end
    end

    task automatic run_seg(input logic [1:0] m, input logic [7:0] p, input logic [23:0] per, input int n);
        int t0, eff, sp;
        @(negedge clk);
        cfg_mode = m; cfg_pattern = p; cfg_period = per; enable = 1'b1;
        t0  = cyc;
        eff = (per == 0) ? 1 : int'(per);
        sp  = step_of(per);
        for (int k = 0; k < n; k++) push(model_seq(m, p, k), 1'b0, t0 + 1 + eff + k * sp);
        wait_cycle(t0 + 1 + eff + (n - 1) * sp);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        q.delete();
    endtask

    // Software request collides with the pending tick of sequencer write ksw.
    task automatic run_sw_seg(input logic [1:0] m, input logic [7:0] p, input logic [23:0] per,
                              input int n, input int ksw, input logic [7:0] d);
        int t0, eff, c, w;
        @(negedge clk);
        cfg_mode = m; cfg_pattern = p; cfg_period = per; enable = 1'b1;
        t0  = cyc;
        eff = int'(per);
        for (int k = 0; k < n; k++) begin
            c = t0 + 1 + eff + k * eff;
            if (k == ksw) begin
                push(d, 1'b1, c);
                push(model_seq(m, p, k), 1'b0, c + 2);
            end else begin
                push(model_seq(m, p, k), 1'b0, c);
            end
        end
        w = t0 + 1 + eff + ksw * eff;
        wait_cycle(w - 1);
        sw_req = 1'b1; sw_data = d;
        wait_cycle(w);
        sw_req = 1'b0;
        wait_cycle(t0 + 1 + eff + (n - 1) * eff);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained_sw", 32'(q.size()), 32'h0);
        q.delete();
    endtask

    task automatic sw_only(input logic [7:0] d);
        int t;
        @(negedge clk);
        t = cyc;
        sw_req = 1'b1; sw_data = d;
        push(d, 1'b1, t + 1);
        wait_cycle(t + 1);
        sw_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained_swonly", 32'(q.size()), 32'h0);
        q.delete();
    endtask

    initial begin
        int t0;
        reset_n = 1'b0; enable = 1'b0; cfg_mode = 2'd0; cfg_pattern = 8'h00;
        cfg_period = 24'd1; sw_req = 1'b0; sw_data = 8'h00;
        #17;
        chk("rst_chipselect", 32'(pio.chipselect), 32'h0);
        chk("rst_write_n",    32'(pio.write_n), 32'h1);
        chk("rst_address",    32'(pio.address), 32'h0);
        chk("rst_writedata",  pio.writedata, 32'h0);
        chk("rst_cur_pattern", 32'(cur_pattern), 32'h0);
        chk("rst_sw_ack",     32'(sw_ack), 32'h0);
        chk("rst_busy",       32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        run_seg(2'd0, 8'hA5, 24'd3, 4);
        run_seg(2'd1, 8'h0F, 24'd2, 4);
        run_seg(2'd3, 8'h00, 24'd1, 16);
        run_seg(2'd2, 8'h81, 24'd0, 6);
        run_sw_seg(2'd0, 8'h55, 24'd4, 4, 1, 8'h3C);
        run_sw_seg(2'd2, 8'h81, 24'd4, 5, 2, 8'hE7);
        sw_only(8'h5A);

        for (int i = 0; i < 8; i++) begin
            run_seg(2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom_range(0, 5)),
                    $urandom_range(4, 20));
        end
        for (int i = 0; i < 3; i++) begin
            int ks;
            ks = $urandom_range(1, 3);
            run_sw_seg(2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom_range(4, 6)),
                       ks + 2 + $urandom_range(0, 2), ks, 8'($urandom));
        end
        sw_only(8'($urandom));

        // Reset asserted while a write is on the bus.
        @(negedge clk);
        cfg_mode = 2'd0; cfg_pattern = 8'hC3; cfg_period = 24'd3; enable = 1'b1;
        t0 = cyc;
        push(8'hC3, 1'b0, t0 + 4);
        wait_cycle(t0 + 4);
        #1 reset_n = 1'b0;
        #1;
        chk("rstwr_chipselect",  32'(pio.chipselect), 32'h0);
        chk("rstwr_write_n",     32'(pio.write_n), 32'h1);
        chk("rstwr_busy",        32'(busy), 32'h0);
        chk("rstwr_cur_pattern", 32'(cur_pattern), 32'h0);
        chk("rstwr_writedata",   pio.writedata, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        t0 = cyc;
        push(8'hC3, 1'b0, t0 + 4);
        wait_cycle(t0 + 2);
        chk("post_rst_cur_pattern", 32'(cur_pattern), 32'h0);
        wait_cycle(t0 + 4);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained_rst", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
